// File: rtl/rv32i_seq.sv
// Multi-cycle control sequencer for the RV32I(+M) core: fetch/decode/execute/mem/mul-div/writeback/trap.
// Optional mul/div wait state enabled by defining RV32I_SEQ_MULDIV_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_RESET  | one idle cycle after reset release
// S_FETCH  | instruction request outstanding, waiting for I_ACK
// S_DECODE | decoder enable pulse
// S_EXEC   | execute pulse, class flags sampled and latched
// S_MEM    | data request outstanding, waiting for D_ACK
// S_MD     | mul/div running, waiting for MD_DONE
// S_WB     | register file / PC commit, interrupt sample point
// S_TRAP   | trap entry: mepc/mcause write, PC to trap vector
module rv32i_seq #(
    parameter int BUS_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       I_ACK,
    input  logic       D_ACK,
    input  logic       IS_LOAD,
    input  logic       IS_STORE,
    input  logic       IS_MULDIV,
    input  logic       IS_ECALL,
    input  logic       IS_EBREAK,
    input  logic       IS_MRET,
    input  logic       ILL_INST,
    input  logic [4:0] RD_NUM,
    input  logic       MD_DONE,
    input  logic       IRQ,
    input  logic       IRQ_EN,
    output logic       I_REQ,
    output logic       D_REQ,
    output logic       D_WE,
    output logic       DEC_EN,
    output logic       EXE_EN,
    output logic       MD_START,
    output logic       RF_WE,
    output logic       PC_WE,
    output logic [1:0] PC_SEL,
    output logic       TRAP_ENTER,
    output logic [4:0] TRAP_CAUSE,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_MD, S_WB, S_TRAP
    } state_t;

    localparam logic [TO_W-1:0] TO_LOAD = (BUS_TIMEOUT == 0) ? '0 : TO_W'(BUS_TIMEOUT - 1);

    state_t          state;
    state_t          nxt;
    logic [4:0]      nxt_cause;
    logic [TO_W-1:0] to_cnt;
    logic            to_exp;
    logic            lat_store;
    logic            lat_mret;
    logic [4:0]      lat_rd;
    logic            cur_store;
    logic            cur_mret;
    logic [4:0]      cur_rd;

`ifndef RV32I_SEQ_MULDIV_EN
    logic unused_md_done;
    assign unused_md_done = MD_DONE;
`endif

    // Outputs are registered from the next state, so the flags must come straight
    // from the decoder on the EXEC edge and from the latches afterwards.
    assign cur_store = (state == S_EXEC) ? IS_STORE : lat_store;
    assign cur_mret  = (state == S_EXEC) ? IS_MRET  : lat_mret;
    assign cur_rd    = (state == S_EXEC) ? RD_NUM   : lat_rd;
    assign to_exp    = (BUS_TIMEOUT != 0) && (to_cnt == '0);

    always_comb begin
        nxt       = state;
        nxt_cause = TRAP_CAUSE;
        case (state)
            S_RESET:  nxt = S_FETCH;
            S_FETCH: begin
                if (I_ACK) begin
                    nxt = S_DECODE;
                end else if (to_exp) begin
                    nxt       = S_TRAP;
                    nxt_cause = 5'h01;
                end
            end
            S_DECODE: nxt = S_EXEC;
            S_EXEC: begin
                if (ILL_INST) begin
                    nxt       = S_TRAP;
                    nxt_cause = 5'h02;
                end else if (IS_EBREAK) begin
                    nxt       = S_TRAP;
                    nxt_cause = 5'h03;
                end else if (IS_ECALL) begin
                    nxt       = S_TRAP;
                    nxt_cause = 5'h0B;
                end else if (IS_LOAD || IS_STORE) begin
                    nxt = S_MEM;
                end else if (IS_MULDIV) begin
`ifdef RV32I_SEQ_MULDIV_EN
                    nxt = S_MD;
`else
                    nxt       = S_TRAP;
                    nxt_cause = 5'h02;
`endif
                end else begin
                    nxt = S_WB;
                end
            end
            S_MEM: begin
                if (D_ACK) begin
                    nxt = S_WB;
                end else if (to_exp) begin
                    nxt       = S_TRAP;
                    nxt_cause = lat_store ? 5'h07 : 5'h05;
                end
            end
`ifdef RV32I_SEQ_MULDIV_EN
            S_MD: begin
                if (MD_DONE) nxt = S_WB;
            end
`endif
            S_WB: begin
                if (IRQ && IRQ_EN) begin
                    nxt       = S_TRAP;
                    nxt_cause = 5'h1B;
                end else begin
                    nxt = S_FETCH;
                end
            end
            S_TRAP:   nxt = S_FETCH;
            default:  nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_RESET;
            to_cnt     <= '0;
            lat_store  <= 1'b0;
            lat_mret   <= 1'b0;
            lat_rd     <= 5'd0;
            I_REQ      <= 1'b0;
            D_REQ      <= 1'b0;
            D_WE       <= 1'b0;
            DEC_EN     <= 1'b0;
            EXE_EN     <= 1'b0;
            MD_START   <= 1'b0;
            RF_WE      <= 1'b0;
            PC_WE      <= 1'b0;
            PC_SEL     <= 2'd0;
            TRAP_ENTER <= 1'b0;
            TRAP_CAUSE <= 5'd0;
            BUSY       <= 1'b0;
        end else begin
            state <= nxt;
            if (state == S_EXEC) begin
                lat_store <= IS_STORE;
                lat_mret  <= IS_MRET;
                lat_rd    <= RD_NUM;
            end
            // Down-counter reloads on every state change, so each request gets a full window.
            if ((state != S_FETCH && state != S_MEM) || nxt != state) begin
                to_cnt <= TO_LOAD;
            end else if (to_cnt != '0) begin
                to_cnt <= to_cnt - TO_W'(1);
            end
            I_REQ  <= (nxt == S_FETCH);
            D_REQ  <= (nxt == S_MEM);
            D_WE   <= (nxt == S_MEM) && cur_store;
            DEC_EN <= (nxt == S_DECODE);
            EXE_EN <= (nxt == S_EXEC);
`ifdef RV32I_SEQ_MULDIV_EN
            MD_START <= (state == S_EXEC) && (nxt == S_MD);
`else
            MD_START <= 1'b0;
`endif
            RF_WE      <= (nxt == S_WB) && !cur_store && !cur_mret && (cur_rd != 5'd0);
            PC_WE      <= (nxt == S_WB) || (nxt == S_TRAP);
            TRAP_ENTER <= (nxt == S_TRAP);
            BUSY       <= (nxt != S_FETCH);
            if (nxt == S_TRAP) begin
                PC_SEL     <= 2'd1;
                TRAP_CAUSE <= nxt_cause;
            end else if (nxt == S_WB && cur_mret) begin
                PC_SEL <= 2'd2;
            end else begin
                PC_SEL <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_seq.sv
// Directed self-checking bench for rv32i_seq; a second instance with the bus timeout disabled.
module tb_rv32i_seq;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       I_ACK, D_ACK, IS_LOAD, IS_STORE, IS_MULDIV, IS_ECALL, IS_EBREAK, IS_MRET;
    logic       ILL_INST, MD_DONE, IRQ, IRQ_EN;
    logic [4:0] RD_NUM;

    logic       I_REQ, D_REQ, D_WE, DEC_EN, EXE_EN, MD_START, RF_WE, PC_WE, TRAP_ENTER, BUSY;
    logic [1:0] PC_SEL;
    logic [4:0] TRAP_CAUSE;

    logic       i_req_0, d_req_0, d_we_0, dec_en_0, exe_en_0, md_start_0, rf_we_0, pc_we_0;
    logic       trap_enter_0, busy_0;
    logic [1:0] pc_sel_0;
    logic [4:0] trap_cause_0;

    int n_checks = 0;
    int n_pass   = 0;

    // Packed view: {I_REQ,D_REQ,D_WE,DEC_EN,EXE_EN,MD_START,RF_WE,PC_WE,PC_SEL[1:0],TRAP_ENTER,BUSY}
    localparam logic [11:0] V_FET     = 12'b1000_0000_0000;
    localparam logic [11:0] V_DEC     = 12'b0001_0000_0001;
    localparam logic [11:0] V_EXE     = 12'b0000_1000_0001;
    localparam logic [11:0] V_MEM_LD  = 12'b0100_0000_0001;
    localparam logic [11:0] V_MEM_ST  = 12'b0110_0000_0001;
    localparam logic [11:0] V_MD_ST   = 12'b0000_0100_0001;
    localparam logic [11:0] V_MD_W    = 12'b0000_0000_0001;
    localparam logic [11:0] V_WB_RF   = 12'b0000_0011_0001;
    localparam logic [11:0] V_WB      = 12'b0000_0001_0001;
    localparam logic [11:0] V_WB_MRET = 12'b0000_0001_1001;
    localparam logic [11:0] V_TRAP    = 12'b0000_0001_0111;

    rv32i_seq #(.BUS_TIMEOUT(16), .TO_W(5)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .I_ACK(I_ACK), .D_ACK(D_ACK),
        .IS_LOAD(IS_LOAD), .IS_STORE(IS_STORE), .IS_MULDIV(IS_MULDIV), .IS_ECALL(IS_ECALL),
        .IS_EBREAK(IS_EBREAK), .IS_MRET(IS_MRET), .ILL_INST(ILL_INST), .RD_NUM(RD_NUM),
        .MD_DONE(MD_DONE), .IRQ(IRQ), .IRQ_EN(IRQ_EN),
        .I_REQ(I_REQ), .D_REQ(D_REQ), .D_WE(D_WE), .DEC_EN(DEC_EN), .EXE_EN(EXE_EN),
        .MD_START(MD_START), .RF_WE(RF_WE), .PC_WE(PC_WE), .PC_SEL(PC_SEL),
        .TRAP_ENTER(TRAP_ENTER), .TRAP_CAUSE(TRAP_CAUSE), .BUSY(BUSY)
    );

    rv32i_seq #(.BUS_TIMEOUT(0), .TO_W(5)) u_dut0 (
        .CLK(CLK), .RST_N(RST_N), .I_ACK(I_ACK), .D_ACK(D_ACK),
        .IS_LOAD(IS_LOAD), .IS_STORE(IS_STORE), .IS_MULDIV(IS_MULDIV), .IS_ECALL(IS_ECALL),
        .IS_EBREAK(IS_EBREAK), .IS_MRET(IS_MRET), .ILL_INST(ILL_INST), .RD_NUM(RD_NUM),
        .MD_DONE(MD_DONE), .IRQ(IRQ), .IRQ_EN(IRQ_EN),
        .I_REQ(i_req_0), .D_REQ(d_req_0), .D_WE(d_we_0), .DEC_EN(dec_en_0), .EXE_EN(exe_en_0),
        .MD_START(md_start_0), .RF_WE(rf_we_0), .PC_WE(pc_we_0), .PC_SEL(pc_sel_0),
        .TRAP_ENTER(trap_enter_0), .TRAP_CAUSE(trap_cause_0), .BUSY(busy_0)
    );

    always #5 CLK = ~CLK;

    function automatic logic [11:0] outs();
        return {I_REQ, D_REQ, D_WE, DEC_EN, EXE_EN, MD_START, RF_WE, PC_WE, PC_SEL, TRAP_ENTER, BUSY};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        I_ACK = 0; D_ACK = 0; IS_LOAD = 0; IS_STORE = 0; IS_MULDIV = 0; IS_ECALL = 0;
        IS_EBREAK = 0; IS_MRET = 0; ILL_INST = 0; MD_DONE = 0; IRQ = 0; IRQ_EN = 0; RD_NUM = 5'd0;
    endtask

    // Leaves both DUTs in their first S_FETCH cycle.
    task automatic apply_reset();
        clear_inputs();
        RST_N = 0;
        tick();
        tick();
        RST_N = 1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        RST_N = 0;
        tick();
        n_checks++;
        if (outs() !== 12'h000) $display("FAIL reset_outs got %b want %b", outs(), 12'h000);
        else n_pass++;
        n_checks++;
        if (TRAP_CAUSE !== 5'd0) $display("FAIL reset_cause got %h want 00", TRAP_CAUSE);
        else n_pass++;
        RST_N = 1;
        #1;
        n_checks++;
        if (outs() !== 12'h000) $display("FAIL reset_hold got %b want %b", outs(), 12'h000);
        else n_pass++;
        tick();
        n_checks++;
        if (outs() !== V_FET) $display("FAIL reset_exit got %b want %b", outs(), V_FET);
        else n_pass++;
    endtask

    task automatic test_addi();
        logic [11:0] ex[5];
        apply_reset();
        RD_NUM = 5'd1;
        ex = '{V_FET, V_DEC, V_EXE, V_WB_RF, V_FET};
        for (int c = 0; c < 5; c++) begin
            I_ACK = (c == 1);
            tick();
            n_checks++;
            if (outs() !== ex[c]) $display("FAIL addi c%0d got %b want %b", c, outs(), ex[c]);
            else n_pass++;
        end
        I_ACK = 0;
    endtask

    task automatic test_load_store();
        logic [11:0] ld[8];
        logic [11:0] st[5];
        IS_LOAD = 1; RD_NUM = 5'd5;
        ld = '{V_DEC, V_EXE, V_MEM_LD, V_MEM_LD, V_MEM_LD, V_MEM_LD, V_WB_RF, V_FET};
        for (int c = 0; c < 8; c++) begin
            I_ACK = (c == 0); D_ACK = (c == 6);
            tick();
            n_checks++;
            if (outs() !== ld[c]) $display("FAIL load c%0d got %b want %b", c, outs(), ld[c]);
            else n_pass++;
        end
        IS_LOAD = 0; IS_STORE = 1; RD_NUM = 5'd3;
        st = '{V_DEC, V_EXE, V_MEM_ST, V_WB, V_FET};
        for (int c = 0; c < 5; c++) begin
            I_ACK = (c == 0); D_ACK = (c == 3);
            tick();
            n_checks++;
            if (outs() !== st[c]) $display("FAIL store c%0d got %b want %b", c, outs(), st[c]);
            else n_pass++;
        end
        clear_inputs();
    endtask

    task automatic test_sync_trap();
        logic [11:0] ex[4];
        logic [4:0]  fl[3];   // {ILL, EBREAK, ECALL, LOAD, STORE}
        logic [4:0]  cz[3];
        ex = '{V_DEC, V_EXE, V_TRAP, V_FET};
        fl = '{5'b10101, 5'b01100, 5'b00101};
        cz = '{5'h02, 5'h03, 5'h0B};
        for (int k = 0; k < 3; k++) begin
            {ILL_INST, IS_EBREAK, IS_ECALL, IS_LOAD, IS_STORE} = fl[k];
            RD_NUM = 5'd9;
            for (int c = 0; c < 4; c++) begin
                I_ACK = (c == 0);
                tick();
                n_checks++;
                if (outs() !== ex[c]) $display("FAIL trap%0d c%0d got %b want %b", k, c, outs(), ex[c]);
                else n_pass++;
            end
            n_checks++;
            if (TRAP_CAUSE !== cz[k]) $display("FAIL trap%0d_cause got %h want %h", k, TRAP_CAUSE, cz[k]);
            else n_pass++;
        end
        clear_inputs();
    endtask

    task automatic test_timeout();
        logic [11:0] want;
        logic [4:0]  cz[2];
        apply_reset();
        for (int c = 0; c < 17; c++) begin
            tick();
            want = (c == 15) ? V_TRAP : V_FET;
            n_checks++;
            if (outs() !== want) $display("FAIL ifetch_to c%0d got %b want %b", c, outs(), want);
            else n_pass++;
        end
        n_checks++;
        if (TRAP_CAUSE !== 5'h01) $display("FAIL ifetch_to_cause got %h want 01", TRAP_CAUSE);
        else n_pass++;
        for (int c = 0; c < 40; c++) tick();
        n_checks++;
        if (i_req_0 !== 1'b1 || trap_cause_0 !== 5'd0)
            $display("FAIL no_timeout got i_req=%b cause=%h want 1/00", i_req_0, trap_cause_0);
        else n_pass++;
        // Ack on the expiry cycle must win over the trap.
        apply_reset();
        for (int c = 0; c < 16; c++) begin
            I_ACK = (c == 15);
            tick();
        end
        I_ACK = 0;
        n_checks++;
        if (outs() !== V_DEC || TRAP_CAUSE !== 5'd0)
            $display("FAIL ack_at_expiry got %b/%h want %b/00", outs(), TRAP_CAUSE, V_DEC);
        else n_pass++;
        apply_reset();
        cz = '{5'h05, 5'h07};
        for (int k = 0; k < 2; k++) begin
            IS_LOAD = (k == 0); IS_STORE = (k == 1); RD_NUM = 5'd2;
            for (int c = 0; c < 19; c++) begin
                I_ACK = (c == 0);
                tick();
                if (c == 17) begin
                    n_checks++;
                    if (D_REQ !== 1'b1) $display("FAIL dto%0d_last_req got %b want 1", k, D_REQ);
                    else n_pass++;
                end
            end
            n_checks++;
            if (outs() !== V_TRAP || TRAP_CAUSE !== cz[k])
                $display("FAIL dto%0d got %b/%h want %b/%h", k, outs(), TRAP_CAUSE, V_TRAP, cz[k]);
            else n_pass++;
            I_ACK = 0;
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_irq();
        logic [11:0] a[5];
        logic [11:0] b[4];
        apply_reset();
        IRQ = 1; IRQ_EN = 1; RD_NUM = 5'd7;
        a = '{V_DEC, V_EXE, V_WB_RF, V_TRAP, V_FET};
        for (int c = 0; c < 5; c++) begin
            I_ACK = (c == 0);
            tick();
            n_checks++;
            if (outs() !== a[c]) $display("FAIL irq c%0d got %b want %b", c, outs(), a[c]);
            else n_pass++;
        end
        n_checks++;
        if (TRAP_CAUSE !== 5'h1B) $display("FAIL irq_cause got %h want 1b", TRAP_CAUSE);
        else n_pass++;
        IRQ_EN = 0;
        b = '{V_DEC, V_EXE, V_WB_RF, V_FET};
        for (int c = 0; c < 4; c++) begin
            I_ACK = (c == 0);
            tick();
            n_checks++;
            if (outs() !== b[c]) $display("FAIL irq_masked c%0d got %b want %b", c, outs(), b[c]);
            else n_pass++;
        end
        // Exception wins over a pending IRQ, which is then taken at the next writeback.
        IRQ_EN = 1; ILL_INST = 1;
        b = '{V_DEC, V_EXE, V_TRAP, V_FET};
        for (int c = 0; c < 4; c++) begin
            I_ACK = (c == 0);
            tick();
            n_checks++;
            if (outs() !== b[c]) $display("FAIL irq_vs_ill c%0d got %b want %b", c, outs(), b[c]);
            else n_pass++;
        end
        n_checks++;
        if (TRAP_CAUSE !== 5'h02) $display("FAIL irq_vs_ill_cause got %h want 02", TRAP_CAUSE);
        else n_pass++;
        ILL_INST = 0;
        for (int c = 0; c < 5; c++) begin
            I_ACK = (c == 0);
            tick();
            n_checks++;
            if (outs() !== a[c]) $display("FAIL irq_after_trap c%0d got %b want %b", c, outs(), a[c]);
            else n_pass++;
        end
        n_checks++;
        if (TRAP_CAUSE !== 5'h1B) $display("FAIL irq_after_trap_cause got %h want 1b", TRAP_CAUSE);
        else n_pass++;
        clear_inputs();
    endtask

    task automatic test_mret_rd0();
        logic [11:0] m[4];
        logic [11:0] z[4];
        IS_MRET = 1; RD_NUM = 5'd4;
        m = '{V_DEC, V_EXE, V_WB_MRET, V_FET};
        for (int c = 0; c < 4; c++) begin
            I_ACK = (c == 0);
            tick();
            n_checks++;
            if (outs() !== m[c]) $display("FAIL mret c%0d got %b want %b", c, outs(), m[c]);
            else n_pass++;
        end
        IS_MRET = 0; RD_NUM = 5'd0;
        z = '{V_DEC, V_EXE, V_WB, V_FET};
        for (int c = 0; c < 4; c++) begin
            I_ACK = (c == 0);
            tick();
            n_checks++;
            if (outs() !== z[c]) $display("FAIL rd0 c%0d got %b want %b", c, outs(), z[c]);
            else n_pass++;
        end
        clear_inputs();
    endtask

    task automatic test_muldiv();
`ifdef RV32I_SEQ_MULDIV_EN
        logic [11:0] w[7];
        logic [11:0] q[5];
        IS_MULDIV = 1; RD_NUM = 5'd2;
        w = '{V_DEC, V_EXE, V_MD_ST, V_MD_W, V_MD_W, V_WB_RF, V_FET};
        for (int c = 0; c < 7; c++) begin
            I_ACK = (c == 0); MD_DONE = (c == 5);
            tick();
            n_checks++;
            if (outs() !== w[c]) $display("FAIL muldiv c%0d got %b want %b", c, outs(), w[c]);
            else n_pass++;
        end
        q = '{V_DEC, V_EXE, V_MD_ST, V_WB_RF, V_FET};
        for (int c = 0; c < 5; c++) begin
            I_ACK = (c == 0); MD_DONE = (c == 3);
            tick();
            n_checks++;
            if (outs() !== q[c]) $display("FAIL muldiv_fast c%0d got %b want %b", c, outs(), q[c]);
            else n_pass++;
        end
`else
        logic [11:0] t[4];
        IS_MULDIV = 1; RD_NUM = 5'd2;
        t = '{V_DEC, V_EXE, V_TRAP, V_FET};
        for (int c = 0; c < 4; c++) begin
            I_ACK = (c == 0); MD_DONE = (c == 2);
            tick();
            n_checks++;
            if (outs() !== t[c]) $display("FAIL muldiv_off c%0d got %b want %b", c, outs(), t[c]);
            else n_pass++;
        end
        n_checks++;
        if (TRAP_CAUSE !== 5'h02) $display("FAIL muldiv_off_cause got %h want 02", TRAP_CAUSE);
        else n_pass++;
`endif
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        IS_LOAD = 1; RD_NUM = 5'd1;
        for (int c = 0; c < 3; c++) begin
            I_ACK = (c == 0);
            tick();
        end
        n_checks++;
        if (outs() !== V_MEM_LD) $display("FAIL rstmid_pre got %b want %b", outs(), V_MEM_LD);
        else n_pass++;
        RST_N = 0;
        #1;
        n_checks++;
        if (outs() !== 12'h000) $display("FAIL rstmid_async got %b want %b", outs(), 12'h000);
        else n_pass++;
        clear_inputs();
        tick();
        RST_N = 1;
        #1;
        n_checks++;
        if (outs() !== 12'h000) $display("FAIL rstmid_sreset got %b want %b", outs(), 12'h000);
        else n_pass++;
        tick();
        n_checks++;
        if (outs() !== V_FET) $display("FAIL rstmid_fetch got %b want %b", outs(), V_FET);
        else n_pass++;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_addi();
        test_load_store();
        test_sync_trap();
        test_mret_rd0();
        test_muldiv();
        test_timeout();
        test_irq();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d/%0d checks", n_pass, n_checks);
        $fatal(1);
    end

endmodule
